// File: rtl/fetch_if.sv
// fetch_if: imem, decode and writeback-PC signals of the fetch stage
interface fetch_if;
    logic [31:0] newPC_i;
    logic        newPCValid_i;
    logic        imemReq_o;
    logic [31:0] imemAddr_o;
    logic        imemAck_i;
    logic [31:0] imemData_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pcPlus4_o;
    logic        instrValid_o;
    logic        instrReady_i;
    logic        fault_o;
    logic [31:0] fetchCount_o;
    modport master (
        input  newPC_i, newPCValid_i, imemAck_i, imemData_i, instrReady_i,
        output imemReq_o, imemAddr_o, instr_o, pc_o, pcPlus4_o, instrValid_o, fault_o, fetchCount_o
    );
    modport slave (
        output newPC_i, newPCValid_i, imemAck_i, imemData_i, instrReady_i,
        input  imemReq_o, imemAddr_o, instr_o, pc_o, pcPlus4_o, instrValid_o, fault_o, fetchCount_o
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: one-in-flight instruction fetch holding the architectural PC
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic rst_n,
    fetch_if.master bus
);
    typedef enum logic [2:0] {BOOT, FETCH, ISSUE, WAIT_PC, FAULT} state_t;
    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, ipc_q, ipc_d, instr_q, instr_d, cnt_q, cnt_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ipc_q   <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end
    // ipc_q tracks the PC of the issued word, since pc_q moves on in WAIT_PC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: if (bus.imemAck_i) begin
                instr_d = bus.imemData_i;
                ipc_d   = pc_q;
                state_d = ISSUE;
            end
            ISSUE: if (bus.instrReady_i) begin
                cnt_d   = cnt_q + 32'd1;
                state_d = WAIT_PC;
            end
            WAIT_PC: if (bus.newPCValid_i) begin
                pc_d    = (bus.newPC_i[1:0] == 2'b00) ? bus.newPC_i : pc_q;
                state_d = (bus.newPC_i[1:0] == 2'b00) ? FETCH : FAULT;
            end
            default: state_d = FAULT;
        endcase
    end
    assign bus.imemReq_o    = (state_q == FETCH);
    assign bus.instrValid_o = (state_q == ISSUE);
    assign bus.fault_o      = (state_q == FAULT);
    assign bus.imemAddr_o   = pc_q;
    assign bus.instr_o      = instr_q;
    assign bus.pc_o         = ipc_q;
    assign bus.pcPlus4_o    = ipc_q + 32'd4;
    assign bus.fetchCount_o = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic checked against a transaction-level model
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    fetch_if bus ();
    fetch_unit #(.RESET_PC(RPC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // model: phase 0 boot, 1 fetching, 2 presenting, 3 awaiting PC, 4 faulted
    int          m_ph;
    logic [31:0] m_pc, m_ipc, m_instr, m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_pc = RPC; m_ipc = RPC; m_instr = 0; m_cnt = 0;
    endtask

    task automatic check_all();
        check("req", 32'(bus.imemReq_o), 32'(m_ph == 1));
        check("addr", bus.imemAddr_o, m_pc);
        check("valid", 32'(bus.instrValid_o), 32'(m_ph == 2));
        check("fault", 32'(bus.fault_o), 32'(m_ph == 4));
        check("instr", bus.instr_o, m_instr);
        check("pc", bus.pc_o, m_ipc);
        check("pc4", bus.pcPlus4_o, m_ipc + 32'd4);
        check("count", bus.fetchCount_o, m_cnt);
    endtask

    task automatic cycle();
        @(posedge clk);
        case (m_ph)
            0: m_ph = 1;
            1: if (bus.imemAck_i) begin m_instr = bus.imemData_i; m_ipc = m_pc; m_ph = 2; end
            2: if (bus.instrReady_i) begin m_cnt = m_cnt + 1; m_ph = 3; end
            3: if (bus.newPCValid_i) begin
                if (bus.newPC_i % 4 == 0) begin m_pc = bus.newPC_i; m_ph = 1; end
                else m_ph = 4;
            end
            default: ;
        endcase
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imemAck_i = 1'b1;
        bus.imemData_i = 32'hDEAD_BEEF;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic drive_random();
        int sel;
        bus.imemAck_i = 1'($urandom_range(0, 1));
        bus.imemData_i = $urandom;
        bus.instrReady_i = 1'($urandom_range(0, 1));
        bus.newPCValid_i = ($urandom_range(0, 3) == 0);
        sel = $urandom_range(0, 15);
        bus.newPC_i = (sel == 0) ? {$urandom_range(0, 32'h3FFF_FFFF), 2'($urandom_range(1, 3))} :
                      (sel == 1) ? 32'hFFFF_FFFC :
                      {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    endtask

    initial begin
        int fault_cycles = 0;
        bus.newPC_i = 0; bus.newPCValid_i = 0; bus.imemAck_i = 0;
        bus.imemData_i = 0; bus.instrReady_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            if (c == 1500) begin
                force dut.cnt_q = 32'hFFFF_FFFF;
                #1;
                release dut.cnt_q;
                m_cnt = 32'hFFFF_FFFF;
            end
            fault_cycles = (m_ph == 4) ? fault_cycles + 1 : 0;
            if (fault_cycles > 20 || $urandom_range(0, 399) == 0) begin
                fault_cycles = 0;
                do_reset();
                drive_random();
            end
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multi-cycle core: it holds the architectural PC, reads one instruction per turn from instruction memory over a req/ack handshake, and presents it to decode with a valid/ready handshake. It then waits for the next PC from the writeback stage before fetching again. It is the consumer of writeback's `newPC_o` and the producer of `pc`/`pcPlus4` for the execute/writeback path, closing the PC loop. Exactly one instruction is in flight at a time.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC loaded at reset; must be word-aligned.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `newPC_i` input 32: next PC from writeback.
- `newPCValid_i` input 1: `newPC_i` is valid this cycle (one-cycle pulse).
- `imemReq_o` output 1: instruction memory read request.
- `imemAddr_o` output 32: read address, equal to the current PC.
- `imemAck_i` input 1: memory returns data this cycle.
- `imemData_i` input 32: instruction word; sampled when `imemReq_o && imemAck_i`.
- `instr_o` output 32: registered instruction word.
- `pc_o` output 32: PC of `instr_o`.
- `pcPlus4_o` output 32: `pc_o + 4`, modulo 2^32.
- `instrValid_o` output 1: `instr_o`/`pc_o` are valid for decode.
- `instrReady_i` input 1: decode accepts the instruction.
- `fault_o` output 1: sticky misaligned-PC fault.
- `fetchCount_o` output 32: count of instructions accepted by decode.

## Operation

- States: BOOT, FETCH, ISSUE, WAIT_PC, FAULT. Reset enters BOOT.
- **BOOT**
  - No outputs asserted.
  - Unconditionally goes to FETCH on the next edge.
- **FETCH**
  - `imemReq_o`=1 and `imemAddr_o`=PC, both held stable until ack.
  - On `imemAck_i`=1: capture `imemData_i` into `instr_o` and go to ISSUE.
  - Ack may arrive in the first FETCH cycle (zero-wait memory).
- **ISSUE**
  - `instrValid_o`=1; `instr_o`, `pc_o` and `pcPlus4_o` are held stable.
  - On `instrReady_i`=1: increment `fetchCount_o` and go to WAIT_PC.
- **WAIT_PC**
  - Waits for `newPCValid_i`.
  - If `newPC_i[1:0]==0`: PC <= `newPC_i`, go to FETCH.
  - Otherwise: go to FAULT. PC is unchanged.
- **FAULT**
  - `fault_o`=1, no requests, `instrValid_o`=0.
  - Left only by reset.
- `newPCValid_i` is ignored in every state except WAIT_PC.
- `imemAck_i` is ignored outside FETCH.
- `instrReady_i` is ignored outside ISSUE.
- Arithmetic:
  - `pcPlus4_o` wraps: 32'hFFFF_FFFC gives 32'h0000_0000.
  - `fetchCount_o` wraps modulo 2^32.
- Reset values:
  - PC = `RESET_PC`; `pc_o` = `RESET_PC`; `pcPlus4_o` = `RESET_PC`+4.
  - `instr_o`=0, `imemReq_o`=0, `instrValid_o`=0, `fault_o`=0, `fetchCount_o`=0.
- Reset asserted mid-operation (any state) aborts immediately and asynchronously:
  - an outstanding request is dropped;
  - a later `imemAck_i` for it is ignored, since the block is then in BOOT.
- `imemReq_o`, `instrValid_o` and `fault_o` are decoded directly from state registers; no combinational path from any input to any output.

## Timing

- Reset release at edge R: BOOT during cycle R; `imemReq_o`=1 from cycle R+1.
- Ack at cycle N (inside FETCH): `instrValid_o`=1 at cycle N+1 with the captured word.
- Ready at cycle N+1: `instrValid_o`=0 and `fetchCount_o` incremented at cycle N+2.
- `newPCValid_i` at cycle M (in WAIT_PC): `imemReq_o`=1 with `imemAddr_o`=`newPC_i` at cycle M+1.
- Minimum turnaround, from request to next request, is 3 cycles plus writeback latency. This assumes zero-wait memory, same-cycle ready, and immediate new PC.
- Backpressure: `instrValid_o` stays high for as many cycles as `instrReady_i` stays low.

## Test plan

- **Reset fetch:** `RESET_PC`=32'h100, ack after 2 wait cycles, data 32'h00500093 -> `imemAddr_o`=32'h100 stable for 3 cycles; then `instr_o`=32'h00500093, `pc_o`=32'h100, `pcPlus4_o`=32'h104, `instrValid_o`=1.
- **Branch redirect:** accept the instruction, pulse `newPCValid_i` with 32'h200 -> next cycle `imemReq_o`=1, `imemAddr_o`=32'h200; `fetchCount_o`=1.
- **Decode backpressure:** hold `instrReady_i`=0 for 5 cycles -> `instrValid_o` and `instr_o` stable all 5 cycles; `fetchCount_o` unchanged until ready.
- **Misaligned PC:** `newPC_i`=32'h202 in WAIT_PC -> `fault_o`=1 next cycle; no further `imemReq_o` for 20 cycles; `rst_n` pulse clears it.
- **Ignored and wrap cases:**
  - spurious `newPCValid_i` during FETCH/ISSUE -> no effect;
  - PC 32'hFFFF_FFFC -> `pcPlus4_o`=0;
  - `fetchCount_o` forced to 32'hFFFF_FFFF then one accept -> 0.
- **Reset mid-fetch:** assert `rst_n`=0 while `imemReq_o`=1 -> `imemReq_o`=0 immediately and all outputs at reset values; a late `imemAck_i` is ignored; fetch restarts at `RESET_PC`.
